// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write-back ports, bypassed reads,
// and a per-register busy scoreboard for issue stall decisions.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_wen0,
    input  logic [XLEN-1:0]     i_wd0,
    input  logic [AW-1:0]       i_wa0,
    input  logic                i_wen1,
    input  logic [XLEN-1:0]     i_wd1,
    input  logic [AW-1:0]       i_wa1,
    input  logic [NRD*AW-1:0]   i_ra,
    output logic [NRD*XLEN-1:0] o_rd,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_iss_en,
    input  logic [AW-1:0]       i_iss_addr,
    output logic [NREG-1:0]     o_busy,
    output logic                o_err,
    input  logic                i_err_clr
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [NREG-1:0]           hit0;
    logic [NREG-1:0]           hit1;
    logic [NREG-1:0]           wclr;
    logic [NREG-1:0]           iset;
    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0][XLEN-1:0] regs;
    logic                      err_hit;

    // Per-entry decode; entry 0 has no decode hits when hardwired to zero
    for (genvar i = 0; i < NREG; i++) begin : g_ent
        localparam bit IMPL = !(ZR && (i == 0));

        assign hit0[i] = IMPL && i_wen0 && (i_wa0 == AW'(i));
        assign hit1[i] = IMPL && i_wen1 && (i_wa1 == AW'(i));
        assign iset[i] = IMPL && i_iss_en && (i_iss_addr == AW'(i));
        assign wclr[i] = hit0[i] | hit1[i];

        if (IMPL) begin : g_reg
            logic [XLEN-1:0] q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    q <= '0;
                else if (hit1[i])
                    q <= i_wd1;
                else if (hit0[i])
                    q <= i_wd0;
            end
            assign regs[i] = q;
        end else begin : g_zero
            assign regs[i] = '0;
        end
    end

    assign err_hit = |(wclr & ~busy_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            o_err  <= 1'b0;
        end else begin
            busy_q <= (busy_q & ~wclr) | iset;
            if (err_hit)
                o_err <= 1'b1;
            else if (i_err_clr)
                o_err <= 1'b0;
        end
    end

    assign o_busy = busy_q;

    // Port 1 has priority on a same-address collision, matching storage
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = i_ra[k*AW +: AW];

        always_comb begin
            rd = regs[ra];
            if (BP && hit1[ra])
                rd = i_wd1;
            else if (BP && hit0[ra])
                rd = i_wd0;
        end

        assign o_rd[k*XLEN +: XLEN] = rd;
        assign o_rd_busy[k] = busy_q[ra] & ~(BP & wclr[ra]);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance plus a 16-entry, 3-read,
// non-bypassed instance, checked through an expectation queue.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        wen0, wen1, iss, err_clr;
    logic [31:0] wd0, wd1;
    logic [4:0]  wa0, wa1, isa;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rdb;
    logic [31:0] busy;
    logic        err;

    logic        b_wen0, b_wen1, b_iss, b_err_clr;
    logic [31:0] b_wd0, b_wd1;
    logic [3:0]  b_wa0, b_wa1, b_isa;
    logic [11:0] b_ra;
    logic [95:0] b_rd;
    logic [2:0]  b_rdb;
    logic [15:0] b_busy;
    logic        b_err;

    regfile_mp u0 (
        .clk(clk), .rstn(rstn),
        .i_wen0(wen0), .i_wd0(wd0), .i_wa0(wa0),
        .i_wen1(wen1), .i_wd1(wd1), .i_wa1(wa1),
        .i_ra(ra), .o_rd(rd), .o_rd_busy(rdb),
        .i_iss_en(iss), .i_iss_addr(isa),
        .o_busy(busy), .o_err(err), .i_err_clr(err_clr)
    );

    regfile_mp #(.NREG(16), .NRD(3), .BYPASS(0)) u1 (
        .clk(clk), .rstn(rstn),
        .i_wen0(b_wen0), .i_wd0(b_wd0), .i_wa0(b_wa0),
        .i_wen1(b_wen1), .i_wd1(b_wd1), .i_wa1(b_wa1),
        .i_ra(b_ra), .o_rd(b_rd), .o_rd_busy(b_rdb),
        .i_iss_en(b_iss), .i_iss_addr(b_isa),
        .o_busy(b_busy), .o_err(b_err), .i_err_clr(b_err_clr)
    );

    typedef struct {
        logic        wen0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        wen1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  isa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        rdb0;
        logic        rdb1;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    localparam int NV = 12;
    vec_t tbl [NV];
    exp_t q [$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] get_act(input int kind, input int port);
        case (kind)
            0: return rd[port*32 +: 32];
            1: return {31'b0, rdb[port]};
            2: return busy;
            3: return {31'b0, err};
            4: return b_rd[port*32 +: 32];
            5: return {31'b0, b_rdb[port]};
            6: return {16'b0, b_busy};
            default: return {31'b0, b_err};
        endcase
    endfunction

    task automatic push(input string nm, input int kind, input int port,
                        input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic check_q();
        exp_t e;
        logic [31:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = get_act(e.kind, e.port);
            n_vec++;
            if (a !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, a, e.exp);
            end
        end
    endtask

    task automatic samp();
        @(negedge clk);
        check_q();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 0; wa0 = 0; wd0 = 0;
        wen1 = 0; wa1 = 0; wd1 = 0;
        iss = 0; isa = 0; err_clr = 0;
        b_wen0 = 0; b_wa0 = 0; b_wd0 = 0;
        b_wen1 = 0; b_wa1 = 0; b_wd1 = 0;
        b_iss = 0; b_isa = 0; b_err_clr = 0;
    endtask

    task automatic apply(input vec_t v);
        wen0 = v.wen0; wa0 = v.wa0; wd0 = v.wd0;
        wen1 = v.wen1; wa1 = v.wa1; wd1 = v.wd1;
        iss = v.iss; isa = v.isa;
        ra = {v.ra1, v.ra0};
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        ra = '0;
        b_ra = '0;

        //           wen0 wa0 wd0        wen1 wa1 wd1     iss isa ra0 ra1
        //           rd0        rd1       rdb0 rdb1 busy    err
        tbl[0]  = '{0, 0, 0,            0, 0, 0,        1, 3, 3, 3,
                    0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 'h1234,       0, 0, 0,        0, 0, 3, 3,
                    'h1234, 'h1234, 0, 0, 'h8, 0};
        tbl[2]  = '{0, 0, 0,            0, 0, 0,        0, 0, 3, 3,
                    'h1234, 'h1234, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0,            0, 0, 0,        1, 7, 7, 3,
                    0, 'h1234, 0, 0, 0, 0};
        tbl[4]  = '{1, 7, 'hAAAA,       1, 7, 'h5555,   0, 0, 7, 7,
                    'h5555, 'h5555, 0, 0, 'h80, 0};
        tbl[5]  = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 7,
                    'h5555, 'h5555, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0,            0, 0, 0,        1, 9, 9, 9,
                    0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 9, 'h99,         0, 0, 0,        1, 9, 9, 9,
                    'h99, 'h99, 0, 0, 'h200, 0};
        tbl[8]  = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 9,
                    'h99, 'h99, 1, 1, 'h200, 0};
        tbl[9]  = '{0, 0, 0,            1, 9, 'h77,     0, 0, 9, 0,
                    'h77, 0, 0, 0, 'h200, 0};
        tbl[10] = '{1, 0, 'hFFFFFFFF,   0, 0, 0,        1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0,            0, 0, 0,        0, 0, 0, 9,
                    0, 'h77, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        ra = {5'd1, 5'd5};
        b_ra = {4'd2, 4'd1, 4'd15};
        push("rst_rd0", 0, 0, 0);
        push("rst_rd1", 0, 1, 0);
        push("rst_rdb0", 1, 0, 0);
        push("rst_rdb1", 1, 1, 0);
        push("rst_busy", 2, 0, 0);
        push("rst_err", 3, 0, 0);
        push("rst_b_rd2", 4, 2, 0);
        push("rst_b_busy", 6, 0, 0);
        push("rst_b_err", 7, 0, 0);
        samp();
        nxt();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            push($sformatf("v%0d_rd0", i), 0, 0, tbl[i].rd0);
            push($sformatf("v%0d_rd1", i), 0, 1, tbl[i].rd1);
            push($sformatf("v%0d_rdb0", i), 1, 0, {31'b0, tbl[i].rdb0});
            push($sformatf("v%0d_rdb1", i), 1, 1, {31'b0, tbl[i].rdb1});
            push($sformatf("v%0d_busy", i), 2, 0, tbl[i].busy);
            push($sformatf("v%0d_err", i), 3, 0, {31'b0, tbl[i].err});
            samp();
            nxt();
        end

        // write to a non-busy register sets the sticky error
        idle();
        wen0 = 1; wa0 = 4; wd0 = 'h44;
        push("err_pre", 3, 0, 0);
        samp();
        nxt();
        idle();
        ra = {5'd0, 5'd4};
        push("err_set", 3, 0, 1);
        push("err_r4", 0, 0, 'h44);
        samp();
        nxt();
        push("err_hold", 3, 0, 1);
        samp();
        nxt();
        err_clr = 1;
        push("err_clr_cyc", 3, 0, 1);
        samp();
        nxt();
        err_clr = 0;
        push("err_cleared", 3, 0, 0);
        samp();
        nxt();
        wen1 = 1; wa1 = 5; wd1 = 'h55; err_clr = 1;
        push("err_win_pre", 3, 0, 0);
        samp();
        nxt();
        idle();
        push("err_set_wins", 3, 0, 1);
        samp();

        // asynchronous reset mid-cycle
        nxt();
        iss = 1; isa = 5;
        nxt();
        idle();
        wen0 = 1; wa0 = 5; wd0 = 'hDEADBEEF;
        nxt();
        idle();
        ra = {5'd6, 5'd5};
        push("pre_rst_r5", 0, 0, 'hDEADBEEF);
        push("pre_rst_err", 3, 0, 1);
        samp();
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        push("arst_rd_r5", 0, 0, 0);
        push("arst_busy", 2, 0, 0);
        push("arst_err", 3, 0, 0);
        push("arst_rdb0", 1, 0, 0);
        check_q();
        wen0 = 1; wa0 = 6; wd0 = 'h66; iss = 1; isa = 6;
        nxt();
        nxt();
        rstn = 1'b1;
        idle();
        push("lost_wr_r6", 0, 1, 0);
        push("lost_iss", 2, 0, 0);
        samp();

        // non-bypassed instance: old value and busy seen in the write cycle
        nxt();
        b_iss = 1; b_isa = 15;
        push("b_pre_busy", 6, 0, 0);
        samp();
        nxt();
        b_iss = 0;
        b_wen0 = 1; b_wa0 = 15; b_wd0 = 'h1;
        b_ra = {4'd15, 4'd15, 4'd15};
        for (int k = 0; k < 3; k++) begin
            push($sformatf("b_old_rd%0d", k), 4, k, 0);
            push($sformatf("b_old_rdb%0d", k), 5, k, 1);
        end
        push("b_busy15", 6, 0, 'h8000);
        samp();
        nxt();
        b_wen0 = 0;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("b_new_rd%0d", k), 4, k, 1);
            push($sformatf("b_new_rdb%0d", k), 5, k, 0);
        end
        push("b_busy_clr", 6, 0, 0);
        push("b_err", 7, 0, 0);
        samp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with write-back bypass and a per-register busy scoreboard. Successor to the single-write, dual-read core register file. Sits between decode/issue and the two write-back sources (ALU and load unit) of the pipelined core. Issue logic uses it to read operands and to detect pending writes for stall decisions.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, ≥ 2. AW = log2(NREG).
- NRD, 2, number of read ports (1–4).
- ZERO_REG, 1, if 1, register 0 reads as zero and ignores writes.
- BYPASS, 1, if 1, same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_wen0  in  1  write enable, port 0 (ALU).
- i_wd0  in  XLEN  write data, port 0.
- i_wa0  in  AW  write address, port 0.
- i_wen1  in  1  write enable, port 1 (load unit).
- i_wd1  in  XLEN  write data, port 1.
- i_wa1  in  AW  write address, port 1.
- i_ra  in  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- o_rd  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN].
- o_rd_busy  out  NRD  port k's register has a pending write.
- i_iss_en  in  1  issue of an instruction that will write i_iss_addr.
- i_iss_addr  in  AW  destination of the issued instruction.
- o_busy  out  NREG  raw scoreboard vector (registered).
- o_err  out  1  sticky: write-back to a non-busy register.
- i_err_clr  in  1  clears o_err.

## Operation
- Storage: NREG × XLEN flops. With ZERO_REG=1, entry 0 is not implemented (reads constant 0).
- Write: on a clk rising edge, the write port with i_wenN=1 stores i_wdN at i_waN. Writes to address 0 are dropped when ZERO_REG=1.
- Same-address dual write: port 1 wins for both the data and the bypass. Port 0's data is discarded. The busy bit is cleared once.
- Read (combinational), per port k, in priority order:
  - address 0 with ZERO_REG=1 gives 0;
  - if BYPASS=1 and a write to that address is active this cycle, port 1's data, else port 0's data;
  - otherwise the stored value.
- Scoreboard: busy[i] is a register.
  - Next value = (busy[i] & ~wclr[i]) | iset[i].
  - wclr[i] = any active write to i.
  - iset[i] = i_iss_en & (i_iss_addr == i).
  - Issue wins over a same-cycle clear: the new producer is pending.
  - With ZERO_REG=1, busy[0] is always 0 and issues to 0 are ignored.
- o_rd_busy[k] = busy[ra_k] & ~(BYPASS & wclr[ra_k]). It never reflects a same-cycle issue.
- Error: on the edge, o_err is set if any active write targets a register with busy=0. Address 0 is excluded when ZERO_REG=1.
  - i_err_clr clears o_err. A set in the same cycle wins over the clear.
- The block does no arithmetic; all values pass through unmodified.

## Timing
- Reset: asynchronous on rstn low.
  - All entries, all busy bits and o_err go to 0.
  - Outputs are valid from the deassertion edge: o_rd = 0, o_rd_busy = 0, o_busy = 0, o_err = 0.
- Reset mid-operation: pending writes and issues on the edge where rstn is low are lost. There is no partial state.
- Write latency: 1 cycle to storage, 0 cycles to read ports with BYPASS=1.
- With BYPASS=0, a read of a register written this cycle returns the old value and busy still set.
- Issue latency: busy is visible on o_busy and o_rd_busy the cycle after i_iss_en.
- No handshake: write-back sources never stall. Issue logic must hold any instruction while its o_rd_busy is set.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rstn low mid-cycle. Then o_rd(r5) = 0 immediately, o_busy = 0 and o_err = 0.
- Bypass: issue r3, then next cycle write port 0 r3 = 0x1234 while reading r3 on all ports. Same cycle: o_rd = 0x1234, o_rd_busy = 0. Next cycle: o_busy[3] = 0.
- Dual write collision: r7 busy, port 0 writes 0xAAAA and port 1 writes 0x5555 to r7. Read gives 0x5555 in the same cycle and afterwards; o_err stays 0.
- Issue plus write-back same register: r9 busy, write r9 and issue r9 in the same cycle. Data is updated and busy[9] = 1 next cycle.
- Zero register: write 0xFFFFFFFF to r0 and issue r0. r0 reads 0, busy[0] = 0, o_err = 0. Then write r4 while not busy: o_err = 1 next cycle; it holds until i_err_clr, then reads 0.
- Parameters: NREG=16, NRD=3, BYPASS=0. Write r15 = 0x1 with r15 busy. Same cycle reads old value with busy = 1; next cycle reads 0x1 with busy = 0.
